// File: rtl/sram_port_arbiter.sv
// ============================================================================
// sram_port_arbiter
// ----------------------------------------------------------------------------
// Shares a single synchronous BRAM port between the IF-stage fetch requester
// (read-only) and the EXE/MEM-stage data requester (loads and stores).
// Both requesters use a req / addr_ok / data_ok handshake. Only one
// transaction is outstanding at a time, so a pipeline stage simply stalls
// until it sees its own addr_ok and, later, its own data_ok.
//
// Build option:
//   ARB_ROUND_ROBIN_EN - when defined, simultaneous requests are granted
//                        alternately, starting with the data port after
//                        reset. When undefined, the data port always wins a
//                        contention and fetch may starve under a continuous
//                        data_req.
//
// Parameters:
//   MEM_LAT  cycles from the mem_en cycle until mem_rdata is valid (1..4)
//   ADDR_W   address width
//   DATA_W   data width (byte-enable width is DATA_W/8)
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   inst_req / inst_addr       fetch request, held until inst_addr_ok
//   inst_addr_ok               fetch accepted this cycle (combinational)
//   inst_data_ok / inst_rdata  fetch data valid this cycle
//   data_req / data_we /
//   data_addr / data_wdata     data request, held until data_addr_ok
//                              (data_we == 0 means load)
//   data_addr_ok               data request accepted this cycle
//   data_data_ok / data_rdata  load data valid or store complete
//   mem_en / mem_we /
//   mem_addr / mem_wdata       BRAM command, driven only in the accept cycle
//   mem_rdata                  BRAM read data, MEM_LAT cycles after mem_en
// ============================================================================
module sram_port_arbiter #(
    parameter int MEM_LAT = 1,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  inst_req,
    input  logic [ADDR_W-1:0]     inst_addr,
    output logic                  inst_addr_ok,
    output logic                  inst_data_ok,
    output logic [DATA_W-1:0]     inst_rdata,

    input  logic                  data_req,
    input  logic [DATA_W/8-1:0]   data_we,
    input  logic [ADDR_W-1:0]     data_addr,
    input  logic [DATA_W-1:0]     data_wdata,
    output logic                  data_addr_ok,
    output logic                  data_data_ok,
    output logic [DATA_W-1:0]     data_rdata,

    output logic                  mem_en,
    output logic [DATA_W/8-1:0]   mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int          BE_W     = DATA_W / 8;
    // The counter is loaded with MEM_LAT-1 so that the response cycle lands
    // exactly MEM_LAT cycles after the accept cycle.
    localparam logic [2:0]  CNT_INIT = 3'(MEM_LAT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state_reg, state_next;
    logic [2:0]  cnt_reg,   cnt_next;
    // Grant of the transaction in flight; also the round-robin pointer.
    // 0 = inst, 1 = data.
    logic        gnt_reg,   gnt_next;

    // Requester index 0 = inst, 1 = data.
    logic [1:0]             req_vec;
    logic                   winner;
    logic                   accept;
    logic                   respond;
    logic [1:0]             addr_ok_vec;
    logic [1:0]             data_ok_vec;
    logic [1:0][DATA_W-1:0] rdata_vec;

    assign req_vec = {data_req, inst_req};

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
`ifdef ARB_ROUND_ROBIN_EN
    // On contention the requester that did not win last time goes first;
    // a sole requester always wins.
    always_comb begin
        if (inst_req && data_req) begin
            winner = ~gnt_reg;
        end else begin
            winner = data_req;
        end
    end
`else
    // Fixed priority: data over inst.
    always_comb begin
        winner = data_req;
    end
`endif

    // Accept/respond are qualified with reset so that every output, including
    // the purely combinational ones, reads 0 while reset is asserted.
    assign accept  = (state_reg == IDLE) && (|req_vec) && !reset;
    assign respond = (state_reg == BUSY) && (cnt_reg == 3'd0) && !reset;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= 3'd0;
            gnt_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            gnt_reg   <= gnt_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        gnt_next   = gnt_reg;
        case (state_reg)
            IDLE: begin
                if (|req_vec) begin
                    state_next = BUSY;
                    cnt_next   = CNT_INIT;
                    gnt_next   = winner;
                end
            end
            BUSY: begin
                // Requests seen here are ignored; they are re-evaluated once
                // the FSM is back in IDLE.
                if (cnt_reg != 3'd0) begin
                    cnt_next = cnt_reg - 3'd1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------------
    // Per-requester handshake outputs: addr_ok only to the current winner in
    // the accept cycle, data_ok only to the granted requester, and rdata
    // forced to zero outside its data_ok cycle.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            assign addr_ok_vec[gi] = accept  && (winner  == 1'(gi));
            assign data_ok_vec[gi] = respond && (gnt_reg == 1'(gi));
            assign rdata_vec[gi]   = data_ok_vec[gi] ? mem_rdata : '0;
        end
    endgenerate

    assign inst_addr_ok = addr_ok_vec[0];
    assign data_addr_ok = addr_ok_vec[1];
    assign inst_data_ok = data_ok_vec[0];
    assign data_data_ok = data_ok_vec[1];
    assign inst_rdata   = rdata_vec[0];
    assign data_rdata   = rdata_vec[1];

    // BRAM command is issued combinationally in the accept cycle so the
    // memory latency starts counting from addr_ok.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (accept) begin
            mem_en = 1'b1;
            if (winner) begin
                mem_addr  = data_addr;
                mem_we    = data_we;
                mem_wdata = data_wdata;
            end else begin
                mem_addr  = inst_addr;
                mem_we    = {BE_W{1'b0}};
                mem_wdata = '0;
            end
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// ============================================================================
// tb_sram_port_arbiter
// ----------------------------------------------------------------------------
// Two arbiter instances share clk/reset: index 0 with MEM_LAT=1, index 1 with
// MEM_LAT=3. Each has a small BRAM model with a MEM_LAT-deep read pipeline.
// Stimulus pushes the expected response (cycle and data) into a per-port
// queue when a request is accepted; a negedge monitor pops and compares on
// every data_ok.
// ============================================================================
module tb_sram_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic init_ram;

    logic [1:0]       inst_req, inst_addr_ok, inst_data_ok;
    logic [1:0]       data_req, data_addr_ok, data_data_ok, mem_en;
    logic [1:0][31:0] inst_addr, inst_rdata, data_addr, data_wdata, data_rdata;
    logic [1:0][31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0][3:0]  data_we, mem_we;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            localparam int LAT = (gi == 0) ? 1 : 3;
            logic [31:0] ram  [0:255];
            logic [31:0] pipe [0:3];

            sram_port_arbiter #(.MEM_LAT(LAT), .ADDR_W(32), .DATA_W(32)) u_dut (
                .clk          (clk),
                .reset        (reset),
                .inst_req     (inst_req[gi]),
                .inst_addr    (inst_addr[gi]),
                .inst_addr_ok (inst_addr_ok[gi]),
                .inst_data_ok (inst_data_ok[gi]),
                .inst_rdata   (inst_rdata[gi]),
                .data_req     (data_req[gi]),
                .data_we      (data_we[gi]),
                .data_addr    (data_addr[gi]),
                .data_wdata   (data_wdata[gi]),
                .data_addr_ok (data_addr_ok[gi]),
                .data_data_ok (data_data_ok[gi]),
                .data_rdata   (data_rdata[gi]),
                .mem_en       (mem_en[gi]),
                .mem_we       (mem_we[gi]),
                .mem_addr     (mem_addr[gi]),
                .mem_wdata    (mem_wdata[gi]),
                .mem_rdata    (mem_rdata[gi])
            );

            always @(posedge clk) begin
                if (init_ram) begin
                    for (int k = 0; k < 256; k++) ram[k] <= 32'h0;
                    ram[0]     <= 32'h02800c0c;
                    ram[1]     <= 32'h11223344;
                    ram[8'h40] <= 32'hcafef00d;
                    ram[8'h41] <= 32'h0badf00d;
                    for (int k = 0; k < 4; k++) pipe[k] <= 32'h0;
                end else begin
                    if (mem_en[gi]) begin
                        pipe[0] <= ram[mem_addr[gi][9:2]];
                        for (int b = 0; b < 4; b++)
                            if (mem_we[gi][b])
                                ram[mem_addr[gi][9:2]][8*b +: 8] <= mem_wdata[gi][8*b +: 8];
                    end
                    for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
                end
            end
            assign mem_rdata[gi] = pipe[LAT-1];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        int          cyc;
        logic [31:0] data;
        bit          chk;
    } exp_t;

    // Queue index = instance*2 + port (port 0 = inst, 1 = data).
    exp_t q0[$], q1[$], q2[$], q3[$];

    task automatic push_exp(input int idx, input int c, input logic [31:0] d, input bit chk);
        exp_t e;
        e.cyc = c; e.data = d; e.chk = chk;
        case (idx)
            0: q0.push_back(e);
            1: q1.push_back(e);
            2: q2.push_back(e);
            default: q3.push_back(e);
        endcase
    endtask

    task automatic mon(input int idx, input logic dok, input logic [31:0] rd);
        exp_t e;
        bit   have;
        have = 1'b0;
        if (dok === 1'b1) begin
            case (idx)
                0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                2: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
                default: if (q3.size() > 0) begin e = q3.pop_front(); have = 1'b1; end
            endcase
            if (!have) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_data_ok port%0d: got data_ok=1, required 0 (cycle %0d)", idx, cyc);
            end else begin
                check($sformatf("data_ok_cycle port%0d", idx), 32'(cyc), 32'(e.cyc));
                if (e.chk) check($sformatf("rdata port%0d", idx), rd, e.data);
            end
        end else begin
            check($sformatf("rdata_zero port%0d", idx), rd, 32'h0);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            mon(k*2,     inst_data_ok[k], inst_rdata[k]);
            mon(k*2 + 1, data_data_ok[k], data_rdata[k]);
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction. Called #1 after a posedge; returns #1 after
    // the posedge that follows the data_ok cycle. The request stays high
    // through the busy cycles to show it is not accepted again early.
    task automatic do_req(input int i, input bit is_data, input logic [3:0] we,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp, input bit chk);
        int lat;
        bit got;
        lat = (i == 0) ? 1 : 3;
        got = 1'b0;
        if (is_data) begin
            data_req[i] = 1'b1; data_we[i] = we; data_addr[i] = addr; data_wdata[i] = wdata;
        end else begin
            inst_req[i] = 1'b1; inst_addr[i] = addr;
        end
        for (int k = 0; k < 12 && !got; k++) begin
            @(negedge clk);
            if ((is_data ? data_addr_ok[i] : inst_addr_ok[i]) === 1'b1) begin
                got = 1'b1;
                check("mem_en@accept",   32'(mem_en[i]), 32'h1);
                check("mem_addr@accept", mem_addr[i], addr);
                check("mem_we@accept",   32'(mem_we[i]), 32'(is_data ? we : 4'h0));
                check("mem_wdata@accept", mem_wdata[i], is_data ? wdata : 32'h0);
                check("other_addr_ok@accept",
                      32'(is_data ? inst_addr_ok[i] : data_addr_ok[i]), 32'h0);
                push_exp(i*2 + (is_data ? 1 : 0), cyc + lat, exp, chk);
            end
            next_cyc();
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout inst%0d: got no addr_ok, required one within 12 cycles", i);
        end
        for (int k = 1; k < lat; k++) begin
            @(negedge clk);
            check("busy_mem_en",       32'(mem_en[i]),       32'h0);
            check("busy_inst_addr_ok", 32'(inst_addr_ok[i]), 32'h0);
            check("busy_data_addr_ok", 32'(data_addr_ok[i]), 32'h0);
            next_cyc();
        end
        inst_req[i] = 1'b0;
        data_req[i] = 1'b0;
        data_we[i]  = 4'h0;
        @(negedge clk);   // data_ok cycle, checked by the monitor
        next_cyc();
    endtask

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    int sched [8];
    int rem_i, rem_d;

    initial begin
        reset = 1'b1; init_ram = 1'b1;
        inst_req = '0; data_req = '0; inst_addr = '0; data_addr = '0;
        data_wdata = '0; data_we = '0;

        // Requests during reset must produce no handshake or BRAM activity.
        next_cyc();
        inst_req = 2'b11; data_req = 2'b11; inst_addr = {32'h1c000004, 32'h1c000000};
        @(negedge clk);
        check("rst_inst_addr_ok", 32'(inst_addr_ok), 32'h0);
        check("rst_data_addr_ok", 32'(data_addr_ok), 32'h0);
        check("rst_mem_en",       32'(mem_en),       32'h0);
        check("rst_mem_addr0",    mem_addr[0],       32'h0);
        next_cyc();
        inst_req = '0; data_req = '0;
        next_cyc();
        reset = 1'b0; init_ram = 1'b0;
        @(negedge clk);
        check("idle_mem_en", 32'(mem_en), 32'h0);
        next_cyc();

        // Fetch, MEM_LAT=1, then confirm idle outputs.
        do_req(0, 1'b0, 4'h0, 32'h1c000000, 32'h0, 32'h02800c0c, 1'b1);
        @(negedge clk);
        check("post_fetch_mem_en",  32'(mem_en[0]),       32'h0);
        check("post_fetch_addr_ok", 32'(inst_addr_ok[0]), 32'h0);
        next_cyc();

        // Store, load back, partial-byte store, load back.
        do_req(0, 1'b1, 4'hF, 32'h100, 32'hdeadbeef, 32'h0,        1'b0);
        do_req(0, 1'b1, 4'h0, 32'h100, 32'h0,        32'hdeadbeef, 1'b1);
        do_req(0, 1'b1, 4'h3, 32'h100, 32'h12345555, 32'h0,        1'b0);
        do_req(0, 1'b1, 4'h0, 32'h100, 32'h0,        32'hdead5555, 1'b1);

        // MEM_LAT=3 load and fetch.
        do_req(1, 1'b1, 4'h0, 32'h100,      32'h0, 32'hcafef00d, 1'b1);
        do_req(1, 1'b0, 4'h0, 32'h1c000004, 32'h0, 32'h11223344, 1'b1);

        // Reset one cycle after a MEM_LAT=3 accept: no response for it.
        data_req[1] = 1'b1; data_we[1] = 4'h0; data_addr[1] = 32'h104;
        @(negedge clk);
        check("abandon_accept", 32'(data_addr_ok[1]), 32'h1);
        next_cyc();
        data_req[1] = 1'b0; reset = 1'b1;
        inst_req[1] = 1'b1; inst_addr[1] = 32'h1c000004;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("rst_busy_inst_addr_ok", 32'(inst_addr_ok[1]), 32'h0);
            check("rst_busy_mem_en",       32'(mem_en[1]),       32'h0);
            check("rst_busy_mem_addr",     mem_addr[1],          32'h0);
            check("rst_busy_data_ok",      32'(data_data_ok[1]), 32'h0);
            next_cyc();
        end
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_inst_accept", 32'(inst_addr_ok[1]), 32'h1);
        push_exp(2, cyc + 3, 32'h11223344, 1'b1);
        next_cyc();
        inst_req[1] = 1'b0;
        repeat (6) next_cyc();

        // Contention on MEM_LAT=1 instance, right after reset.
`ifdef ARB_ROUND_ROBIN_EN
        sched = '{2, 0, 1, 0, 2, 0, 1, 0};
        rem_d = 2; rem_i = 2;
`else
        sched = '{2, 0, 1, 0, 0, 0, 0, 0};
        rem_d = 1; rem_i = 1;
`endif
        inst_req[0] = 1'b1; inst_addr[0] = 32'h1c000000;
        data_req[0] = 1'b1; data_we[0] = 4'h0; data_addr[0] = 32'h104;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check($sformatf("cont_data_addr_ok c%0d", c), 32'(data_addr_ok[0]), 32'(sched[c] == 2));
            check($sformatf("cont_inst_addr_ok c%0d", c), 32'(inst_addr_ok[0]), 32'(sched[c] == 1));
            if (data_addr_ok[0] === 1'b1) begin
                push_exp(1, cyc + 1, 32'h0badf00d, 1'b1);
                rem_d--;
            end
            if (inst_addr_ok[0] === 1'b1) begin
                push_exp(0, cyc + 1, 32'h02800c0c, 1'b1);
                rem_i--;
            end
            next_cyc();
            if (rem_d <= 0) data_req[0] = 1'b0;
            if (rem_i <= 0) inst_req[0] = 1'b0;
        end
        inst_req[0] = 1'b0; data_req[0] = 1'b0;

        repeat (6) next_cyc();
        check("responses_outstanding", 32'(q0.size() + q1.size() + q2.size() + q3.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one synchronous data/instruction BRAM port between two requesters: the IF-stage fetch port (read-only) and the EXE/MEM-stage data port (loads and stores).
- Each requester uses a req / addr_ok / data_ok handshake, with one outstanding transaction total.
- Fixed-priority arbitration by default; round-robin is an optional build feature.
- The pipeline stages stall on addr_ok/data_ok instead of assuming single-cycle memory.

Parameters:
- MEM_LAT, 1: cycles from the mem_en cycle until mem_rdata is valid. Legal range 1..4.
- ADDR_W, 32: address width.
- DATA_W, 32: data width; byte-enable width is DATA_W/8.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- inst_req  in  1  fetch request; held with inst_addr until inst_addr_ok.
- inst_addr  in  ADDR_W  fetch address.
- inst_addr_ok  out  1  fetch request accepted this cycle.
- inst_data_ok  out  1  fetch data valid this cycle.
- inst_rdata  out  DATA_W  fetch data.
- data_req  in  1  data request; held with we/addr/wdata until data_addr_ok.
- data_we  in  DATA_W/8  byte write enables; 0 means load.
- data_addr  in  ADDR_W  data address.
- data_wdata  in  DATA_W  store data.
- data_addr_ok  out  1  data request accepted this cycle.
- data_data_ok  out  1  load data valid or store complete this cycle.
- data_rdata  out  DATA_W  load data.
- mem_en  out  1  BRAM enable.
- mem_we  out  DATA_W/8  BRAM byte write enables.
- mem_addr  out  ADDR_W  BRAM address.
- mem_wdata  out  DATA_W  BRAM write data.
- mem_rdata  in  DATA_W  BRAM read data, valid MEM_LAT cycles after the en cycle.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high, named reset.
- State machine: IDLE and BUSY. A 3-bit latency counter cnt and a grant register gnt (0 = inst, 1 = data) are held in state.
- Reset:
  - state = IDLE, cnt = 0, gnt = 0 (round-robin pointer = inst).
  - While reset is high, all outputs are 0, including the combinational addr_ok and mem_* outputs.
- IDLE, no req: all outputs 0.
- IDLE, any req:
  - Select the winner: data wins whenever data_req = 1 (fixed priority).
  - Same cycle, combinationally:
    - winner's addr_ok = 1;
    - mem_en = 1;
    - mem_addr = winner address;
    - mem_we = data_we if data wins, else 0;
    - mem_wdata = data_wdata if data wins, else 0.
  - The loser's addr_ok = 0; its request stays pending.
  - Next state BUSY; cnt <= MEM_LAT - 1; gnt <= winner.
- BUSY:
  - mem_en = 0 and both addr_ok = 0; no new acceptance.
  - If cnt != 0: cnt <= cnt - 1.
  - If cnt == 0: the granted requester's data_ok = 1 and its rdata = mem_rdata; next state IDLE.
- Latency and throughput:
  - data_ok comes exactly MEM_LAT cycles after the addr_ok cycle.
  - Back-to-back throughput is one transaction per MEM_LAT+1 cycles; a held request is accepted in the cycle after data_ok.
- rdata outputs are 0 when their data_ok = 0.
- Stores also return data_ok (completion) with data_rdata = mem_rdata. The requester ignores that value.
- data_ok is never asserted to the non-granted requester.
- Simultaneous requests: exactly one addr_ok per cycle; the other requester waits at least MEM_LAT+1 cycles.
- Request dropped before addr_ok: legal, nothing issued.
- Request dropped after addr_ok: no effect; the response is still delivered.
- Reset mid-BUSY: the transaction is abandoned and no data_ok is produced. The next cycle is IDLE.
- Requests arriving during BUSY are not visible until IDLE.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - When both requests are present in IDLE, the winner is the requester not granted last time (pointer = gnt).
  - A sole requester always wins.
  - The pointer resets to inst, so after reset the data port wins the first contention.
- Undefined: fixed data-over-inst priority as above. Fetch may starve under continuous data_req.

Test Plan:
- MEM_LAT=1, inst_req=1, inst_addr=0x1c000000, BRAM word 0x02800c0c:
  - inst_addr_ok=1 and mem_en=1 with mem_addr=0x1c000000 in cycle t;
  - inst_data_ok=1 with inst_rdata=0x02800c0c in t+1;
  - IDLE in t+2.
- MEM_LAT=1, data_req=1, data_we=0xF, addr=0x100, wdata=0xdeadbeef:
  - mem_we=0xF in the accept cycle, data_data_ok=1 next cycle;
  - a subsequent load from 0x100 returns 0xdeadbeef.
- Both requests held from t (fixed priority):
  - data accepted at t, data_data_ok at t+1;
  - inst accepted at t+2, inst_data_ok at t+3;
  - inst_addr_ok=0 at t.
- MEM_LAT=3, data load:
  - data_data_ok exactly 3 cycles after data_addr_ok;
  - mem_en=0 and both addr_ok=0 in the intermediate cycles.
- Reset asserted one cycle after a MEM_LAT=3 accept:
  - no data_ok ever for that request; all outputs 0 during reset;
  - a new inst_req after reset is accepted in its first cycle.
- ARB_ROUND_ROBIN_EN, both requests continuously held, MEM_LAT=1:
  - grants alternate data, inst, data, inst;
  - addr_ok at t, t+2, t+4, t+6.
